// File: rtl/sync_tff_counter.sv
// -----------------------------------------------------------------------------
// sync_tff_counter
//   Synchronous modulo-MOD up/down counter whose state bits behave as T flip-flop
//   cells. Each cycle the block works out the desired next count, then derives
//   the per-bit toggle vector t_vec = next ^ count. The count register only ever
//   updates by toggling the bits selected by t_vec, so there is no direct D-path
//   into the count bits.
//
// Parameters
//   WIDTH    count width in bits (1..16)
//   Modulus  count range 0..MOD-1, 2 <= MOD <= 2**WIDTH
//
// Ports
//   clk       in   rising-edge clock
//   rstn      in   asynchronous active-low reset (count=0, tc=0, t_vec=0)
//   clr       in   synchronous clear to 0 (highest priority)
//   load      in   synchronous parallel load, load_val clamped to MOD-1
//   load_val  in   [WIDTH-1:0] load value
//   en        in   count enable
//   up_dn     in   1 = count up, 0 = count down
//   count     out  [WIDTH-1:0] current count (T cell Q outputs)
//   tc        out  terminal count, combinational; usable as the en of a
//                  cascaded stage on the same clock
//   t_vec     out  [WIDTH-1:0] per-bit toggle vector into the T cells
//
// Configuration
//   SYNC_TFF_COUNTER_SAT_EN  defined: saturate at MOD-1 (up) / 0 (down) instead
//                            of wrapping. tc keeps its definition and stays high
//                            while saturated and enabled. Undefined: wrap-around.
// -----------------------------------------------------------------------------
module sync_tff_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic [WIDTH-1:0] t_vec
);

  // Illegal parameter settings would make out-of-range counts reachable.
  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("sync_tff_counter: WIDTH=%0d outside 1..16", WIDTH);
  end
  if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_mod
    $error("sync_tff_counter: MOD=%0d outside 2..2**WIDTH", MOD);
  end

  // Modulus-related constants held one bit wider so MOD=2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MOD);
  localparam logic [WIDTH:0]   ONE_X = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] next_d;
  logic [WIDTH:0]   inc_x;
  logic [WIDTH:0]   dec_x;
  logic             up_wrap;
  logic             down_wrap;
  logic [WIDTH-1:0] load_clamped;

  // +1/-1 in WIDTH+1 bits; the wrap decision is made before truncation so a
  // full-range modulus (MOD=2**WIDTH) wraps without aliasing.
  assign inc_x     = {1'b0, count_q} + ONE_X;
  assign dec_x     = {1'b0, count_q} - ONE_X;
  assign up_wrap   = (inc_x == MOD_X);
  assign down_wrap = dec_x[WIDTH];   // borrow out means count was 0

  assign load_clamped = ({1'b0, load_val} >= MOD_X) ? MAX_V : load_val;

  always_comb begin
    next_d = count_q;
    if (clr) begin
      next_d = '0;
    end else if (load) begin
      next_d = load_clamped;
    end else if (en) begin
      if (up_dn) begin
`ifdef SYNC_TFF_COUNTER_SAT_EN
        next_d = up_wrap ? count_q : inc_x[WIDTH-1:0];
`else
        next_d = up_wrap ? '0 : inc_x[WIDTH-1:0];
`endif
      end else begin
`ifdef SYNC_TFF_COUNTER_SAT_EN
        next_d = down_wrap ? count_q : dec_x[WIDTH-1:0];
`else
        next_d = down_wrap ? MAX_V : dec_x[WIDTH-1:0];
`endif
      end
    end
  end

  // Toggle vector is forced quiet while reset is held so the observe port
  // never shows phantom toggles.
  assign t_vec = rstn ? (next_d ^ count_q) : '0;

  assign tc = rstn & en & ~clr & ~load &
              ((up_dn & up_wrap) | (~up_dn & down_wrap));

  // T cells: each bit flips exactly where its toggle input is set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_q ^ t_vec;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_sync_tff_counter.sv
module tb_sync_tff_counter;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         clr = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         en = 1'b0;
  logic         up_dn = 1'b0;
  logic [W-1:0] count;
  logic         tc;
  logic [W-1:0] t_vec;

  int tests = 0;
  int fails = 0;
  int m_count = 0;

  sync_tff_counter #(.WIDTH(W), .MOD(M)) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up_dn(up_dn), .count(count), .tc(tc), .t_vec(t_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: next count from the behavioural rules with plain modular arithmetic.
  function automatic int ref_next(input int c, input bit c_clr, input bit c_load,
                                  input int lv, input bit c_en, input bit ud);
    if (c_clr) return 0;
    if (c_load) return (lv >= M) ? M - 1 : lv;
    if (!c_en) return c;
`ifdef SYNC_TFF_COUNTER_SAT_EN
    if (ud) return (c == M - 1) ? c : c + 1;
    return (c == 0) ? c : c - 1;
`else
    if (ud) return (c + 1) % M;
    return (c + M - 1) % M;
`endif
  endfunction

  // Compare on the falling edge, advance the model on the rising edge.
  always begin
    int nx;
    bit etc;
    @(negedge clk);
    if (!rstn) m_count = 0;
    nx  = ref_next(m_count, clr, load, int'(load_val), en, up_dn);
    etc = rstn && en && !clr && !load &&
          (up_dn ? (m_count == M - 1) : (m_count == 0));
    chk("model_count", 32'(count), 32'(m_count));
    chk("model_tc",    32'(tc),    32'(etc));
    chk("model_tvec",  32'(t_vec), rstn ? 32'((nx ^ m_count) & ((1 << W) - 1)) : 32'd0);
    @(posedge clk);
    if (rstn) m_count = ref_next(m_count, clr, load, int'(load_val), en, up_dn);
    else      m_count = 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    // Reset held with en=1/up_dn=0 at count 0: tc and t_vec must still be 0.
    en = 1'b1; up_dn = 1'b0;
    tick(); tick();
    at_neg();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_tc",    32'(tc),    32'd0);
    chk("rst_tvec",  32'(t_vec), 32'd0);

    // Release, count up to 7, then pull reset between edges.
    tick();
    rstn = 1'b1; up_dn = 1'b1;
    repeat (7) tick();
    at_neg();
    chk("pre_rst_7", 32'(count), 32'd7);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_tc",    32'(tc),    32'd0);
    tick();
    rstn = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      at_neg();
      chk("post_rst_seq", 32'(count), 32'(i));
    end

    // Up count 0..9 then wrap.
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0; up_dn = 1'b1; en = 1'b1;
    repeat (9) tick();
    at_neg();
    chk("up_9",      32'(count), 32'd9);
    chk("up_9_tc",   32'(tc),    32'd1);
`ifndef SYNC_TFF_COUNTER_SAT_EN
    chk("up_wrap_tvec", 32'(t_vec), 32'b1001);
    tick();
    at_neg();
    chk("up_wrap_0", 32'(count), 32'd0);
    chk("up_0_tc",   32'(tc),    32'd0);

    // Down count from 0 wraps to 9.
    up_dn = 1'b0;
    #1;
    chk("dn_0_tc",   32'(tc),    32'd1);
    chk("dn_wrap_tvec", 32'(t_vec), 32'b1001);
    tick();
    at_neg();
    chk("dn_9", 32'(count), 32'd9);
    tick();
    at_neg();
    chk("dn_8", 32'(count), 32'd8);
`endif

    // Load, clamp, clr-over-load.
    tick();
    load = 1'b1; load_val = 4'd5; en = 1'b1;
    tick(); at_neg();
    chk("load_5", 32'(count), 32'd5);
    load_val = 4'd12;
    tick(); at_neg();
    chk("load_clamp_12", 32'(count), 32'd9);
    clr = 1'b1; load_val = 4'd7;
    tick(); at_neg();
    chk("clr_over_load", 32'(count), 32'd0);
    clr = 1'b0; load_val = 4'd15;
    tick(); at_neg();
    chk("load_clamp_15", 32'(count), 32'd9);

    // Hold with en=0, then direction change at 4.
    tick();
    load_val = 4'd4;
    tick();
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      up_dn = 1'($urandom);
      #1;
      chk("hold_count", 32'(count), 32'd4);
      chk("hold_tvec",  32'(t_vec), 32'd0);
      chk("hold_tc",    32'(tc),    32'd0);
      tick();
    end
    en = 1'b1; up_dn = 1'b0;
    tick(); at_neg();
    chk("dir_change_3", 32'(count), 32'd3);

`ifdef SYNC_TFF_COUNTER_SAT_EN
    tick();
    load = 1'b1; load_val = 4'd8;
    tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("sat_9",    32'(count), 32'd9);
      chk("sat_tc",   32'(tc),    32'd1);
      chk("sat_tvec", 32'(t_vec), 32'd0);
      tick();
    end
    up_dn = 1'b0;
    tick(); at_neg();
    chk("sat_down_8", 32'(count), 32'd8);
`endif

    // Randomised traffic with occasional mid-cycle reset pulses.
    tick();
    for (int i = 0; i < 3000; i++) begin
      rstn     = 1'b1;
      clr      = ($urandom_range(15) == 0);
      load     = ($urandom_range(7) == 0);
      load_val = W'($urandom);
      en       = ($urandom_range(3) != 0);
      up_dn    = ($urandom_range(9) < 6);
      if ($urandom_range(99) == 0) begin
        #2 rstn = 1'b0;
      end
      tick();
    end
    rstn = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
